// File: rtl/lib_islip_scheduler.sv
// lib_islip_scheduler
//   iSLIP crossbar scheduler for an N-input by M-output switch. It latches a
//   request matrix, then runs up to ITER request-grant-accept iterations, one
//   per clock. It presents the resulting conflict-free match until the
//   consumer takes it.
//   Ports:
//     clk, reset      - clock; asynchronous active-high reset
//     i_request       - [i][j] set: input i has traffic for output j
//     i_req_valid     - i_request valid (sampled only in IDLE)
//     o_req_ready     - high in IDLE
//     o_match         - [i][j] set: input i matched to output j
//     o_match_valid   - high in DONE, o_match is final
//     i_match_ready   - consumer accepts o_match
module lib_islip_scheduler #(
    parameter int unsigned N    = 4,
    parameter int unsigned M    = 4,
    parameter int unsigned ITER = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:N-1][0:M-1]   i_request,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    output logic [0:N-1][0:M-1]   o_match,
    output logic                  o_match_valid,
    input  logic                  i_match_ready
);

    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned IW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ITERATE, S_DONE} state_t;

    state_t                 state_q;
    logic                   ready_q, valid_q;
    logic [0:N-1][0:M-1]    req_q, match_q, match_d;
    logic [M-1:0][GW-1:0]   gptr_q, gptr_d;   // one grant pointer per output
    logic [N-1:0][AW-1:0]   aptr_q, aptr_d;   // one accept pointer per input
    logic [IW-1:0]          iter_q;

    logic [0:N-1][0:M-1]    grant, accept;
    logic [N-1:0]           row_busy;
    logic [M-1:0]           col_busy;
    logic                   any_new, last_iter;

    always_comb begin
        row_busy = '0;
        col_busy = '0;
        grant    = '0;
        accept   = '0;
        for (int unsigned i = 0; i < N; i++)
            for (int unsigned j = 0; j < M; j++)
                if (match_q[i][j]) begin
                    row_busy[i] = 1'b1;
                    col_busy[j] = 1'b1;
                end

        // Grant: each free output picks the first free requesting input at or
        // after its pointer, wrapping round.
        for (int unsigned j = 0; j < M; j++) begin
            logic        found;
            int unsigned base, idx;
            found = 1'b0;
            base  = {{(32-GW){1'b0}}, gptr_q[j]};
            idx   = 0;
            if (!col_busy[j])
                for (int unsigned k = 0; k < N; k++) begin
                    idx = (base + k) % N;
                    if (!found && !row_busy[idx] && req_q[idx][j]) begin
                        grant[idx][j] = 1'b1;
                        found         = 1'b1;
                    end
                end
        end

        // Accept: each free input picks the first granting output at or after
        // its pointer, wrapping round.
        for (int unsigned i = 0; i < N; i++) begin
            logic        found;
            int unsigned base, idx;
            found = 1'b0;
            base  = {{(32-AW){1'b0}}, aptr_q[i]};
            idx   = 0;
            if (!row_busy[i])
                for (int unsigned k = 0; k < M; k++) begin
                    idx = (base + k) % M;
                    if (!found && grant[i][idx]) begin
                        accept[i][idx] = 1'b1;
                        found          = 1'b1;
                    end
                end
        end

        any_new   = |accept;
        last_iter = (iter_q == IW'(ITER - 1));
        match_d   = match_q | accept;

        // Pointers only move on pairs accepted in the first iteration; this is
        // what desynchronises the output arbiters over successive schedules.
        gptr_d = gptr_q;
        aptr_d = aptr_q;
        if (iter_q == '0)
            for (int unsigned i = 0; i < N; i++)
                for (int unsigned j = 0; j < M; j++)
                    if (accept[i][j]) begin
                        gptr_d[j] = GW'((i + 1) % N);
                        aptr_d[i] = AW'((j + 1) % M);
                    end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            req_q   <= '0;
            match_q <= '0;
            gptr_q  <= '0;
            aptr_q  <= '0;
            iter_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_req_valid) begin
                        req_q   <= i_request;
                        match_q <= '0;
                        iter_q  <= '0;
                        ready_q <= 1'b0;
                        state_q <= S_ITERATE;
                    end
                end
                S_ITERATE: begin
                    match_q <= match_d;
                    gptr_q  <= gptr_d;
                    aptr_q  <= aptr_d;
                    iter_q  <= iter_q + IW'(1);
                    if (!any_new || last_iter) begin
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_match_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready   = ready_q;
    assign o_match_valid = valid_q;
    assign o_match       = match_q;

endmodule

// File: tb/tb_lib_islip_scheduler.sv
// Testbench for lib_islip_scheduler (N=M=4, ITER=3): directed schedules with
// constant expectations plus random schedules checked against a reference
// model, all through a scoreboard queue.
module tb_lib_islip_scheduler;

    typedef logic [0:3][0:3] mat_t;
    typedef struct {
        mat_t m;
        int   lat;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    mat_t i_request = '0;
    logic i_req_valid = 1'b0;
    logic o_req_ready;
    mat_t o_match;
    logic o_match_valid;
    logic i_match_ready = 1'b0;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];
    int mg[4];   // model grant pointers (per output)
    int ma[4];   // model accept pointers (per input)

    always #5 clk = ~clk;

    lib_islip_scheduler #(.N(4), .M(4), .ITER(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_request     (i_request),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .o_match       (o_match),
        .o_match_valid (o_match_valid),
        .i_match_ready (i_match_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic mat_t pair(input int i, input int j);
        mat_t m;
        m = '0;
        m[i][j] = 1'b1;
        return m;
    endfunction

    // Reference iSLIP: integer grant/accept choices per iteration.
    task automatic model(input mat_t req, output mat_t m, output int lat);
        int g[4];
        bit rb[4], cb[4];
        bit added;
        m = '0;
        lat = 3;
        for (int it = 0; it < 3; it++) begin
            for (int x = 0; x < 4; x++) begin
                rb[x] = 1'b0;
                cb[x] = 1'b0;
            end
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    if (m[i][j]) begin
                        rb[i] = 1'b1;
                        cb[j] = 1'b1;
                    end
            for (int j = 0; j < 4; j++) begin
                g[j] = -1;
                if (!cb[j])
                    for (int k = 0; k < 4 && g[j] < 0; k++)
                        if (!rb[(mg[j]+k)%4] && req[(mg[j]+k)%4][j]) g[j] = (mg[j]+k)%4;
            end
            added = 1'b0;
            for (int i = 0; i < 4; i++) begin
                int a;
                a = -1;
                if (!rb[i])
                    for (int k = 0; k < 4 && a < 0; k++)
                        if (g[(ma[i]+k)%4] == i) a = (ma[i]+k)%4;
                if (a >= 0) begin
                    m[i][a] = 1'b1;
                    added = 1'b1;
                    if (it == 0) begin
                        mg[a] = (i + 1) % 4;
                        ma[i] = (a + 1) % 4;
                    end
                end
            end
            if (!added) begin
                lat = it + 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int x = 0; x < 4; x++) begin
            mg[x] = 0;
            ma[x] = 0;
        end
    endtask

    task automatic check_ptrs(input string tag, input int g0, input int g1, input int g2,
                              input int g3, input int a0, input int a1, input int a2, input int a3);
        int ge[4], ae[4];
        ge = '{g0, g1, g2, g3};
        ae = '{a0, a1, a2, a3};
        for (int x = 0; x < 4; x++) begin
            chk($sformatf("%s gptr%0d", tag, x), 64'(dut.gptr_q[x]), 64'(ge[x]));
            chk($sformatf("%s aptr%0d", tag, x), 64'(dut.aptr_q[x]), 64'(ae[x]));
        end
    endtask

    // Handshake one request, wait for the match, compare against the popped
    // expectation, optionally stall the consumer, then release.
    task automatic run(input mat_t req, input int hold);
        int   cyc;
        exp_t e;
        @(negedge clk);
        i_request   = req;
        i_req_valid = 1'b1;
        @(posedge clk);
        #1;
        // keep valid high with junk while busy: must be ignored
        i_request = mat_t'($urandom);
        cyc = 0;
        while (!o_match_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        i_req_valid = 1'b0;
        e = sb.pop_front();
        chk({e.tag, " valid"}, 64'(o_match_valid), 64'd1);
        chk({e.tag, " latency"}, 64'(cyc), 64'(e.lat));
        chk({e.tag, " match"}, 64'(o_match), 64'(e.m));
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            chk({e.tag, " hold match"}, 64'(o_match), 64'(e.m));
            chk({e.tag, " hold valid"}, 64'(o_match_valid), 64'd1);
            chk({e.tag, " hold ready"}, 64'(o_req_ready), 64'd0);
        end
        @(negedge clk);
        i_match_ready = 1'b1;
        @(posedge clk);
        #1;
        i_match_ready = 1'b0;
        chk({e.tag, " release valid"}, 64'(o_match_valid), 64'd0);
        chk({e.tag, " release ready"}, 64'(o_req_ready), 64'd1);
    endtask

    task automatic push_const(input mat_t req, input mat_t m, input int lat, input string tag);
        mat_t dm;
        int   dl;
        model(req, dm, dl);   // advances model pointers only
        sb.push_back('{m, lat, tag});
    endtask

    initial begin
        mat_t ones, r, m;
        int   l;
        ones = '1;

        reset = 1'b1;
        #2;
        chk("reset ready", 64'(o_req_ready), 64'd1);
        chk("reset valid", 64'(o_match_valid), 64'd0);
        chk("reset match", 64'(o_match), 64'd0);
        do_reset();

        // single request [0][2]
        push_const(pair(0, 2), pair(0, 2), 2, "single");
        run(pair(0, 2), 0);
        chk("single gptr2", 64'(dut.gptr_q[2]), 64'd1);
        chk("single aptr0", 64'(dut.aptr_q[0]), 64'd3);

        // all-ones from reset, then again to show desynchronisation
        do_reset();
        push_const(ones, pair(0, 0) | pair(1, 1) | pair(2, 2), 3, "ones1");
        run(ones, 0);
        check_ptrs("ones1", 1, 0, 0, 0, 1, 0, 0, 0);
        push_const(ones, pair(0, 1) | pair(1, 0) | pair(2, 2) | pair(3, 3), 3, "ones2");
        run(ones, 5);
        check_ptrs("ones2", 2, 1, 0, 0, 2, 1, 0, 0);

        // all-zero request: one iteration, pointers untouched
        push_const('0, '0, 1, "zero");
        run('0, 0);
        check_ptrs("zero", 2, 1, 0, 0, 2, 1, 0, 0);

        // random schedules against the model
        for (int t = 0; t < 24; t++) begin
            r = mat_t'($urandom);
            if (t % 6 == 5) r = mat_t'($urandom) & mat_t'($urandom);
            model(r, m, l);
            sb.push_back('{m, l, $sformatf("rnd%0d", t)});
            run(r, t % 3);
            check_ptrs($sformatf("rnd%0d", t), mg[0], mg[1], mg[2], mg[3],
                       ma[0], ma[1], ma[2], ma[3]);
        end

        // reset mid-ITERATE discards the schedule and clears pointers
        do_reset();
        push_const(ones, pair(0, 0) | pair(1, 1) | pair(2, 2), 3, "pre");
        run(ones, 0);
        @(negedge clk);
        i_request   = ones;
        i_req_valid = 1'b1;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst valid", 64'(o_match_valid), 64'd0);
        chk("midrst ready", 64'(o_req_ready), 64'd1);
        chk("midrst match", 64'(o_match), 64'd0);
        check_ptrs("midrst", 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        push_const(ones, pair(0, 0) | pair(1, 1) | pair(2, 2), 3, "post");
        run(ones, 0);

        chk("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lib_islip_scheduler.md
LIB_ISLIP_SCHEDULER -- requirements
Module: lib_islip_scheduler

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of inputs (requesters), N >= 2.
REQ-002 SHALL have parameter M, default 4, meaning number of outputs (resources), M >= 2.
REQ-003 SHALL have parameter ITER, default 3, meaning maximum number of request-grant-accept iterations per schedule, ITER >= 1.
REQ-004 SHALL have port clk, input, 1 bit; the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-006 SHALL have port i_request, input, [0:N-1][0:M-1]; row i, bit j set = input i has traffic for output j.
REQ-007 SHALL have port i_req_valid, input, 1 bit; i_request is valid.
REQ-008 SHALL have port o_req_ready, output, 1 bit; block can accept a request matrix.
REQ-009 SHALL have port o_match, output, [0:N-1][0:M-1]; bit [i][j] set = input i matched to output j.
REQ-010 SHALL have port o_match_valid, output, 1 bit; o_match is final.
REQ-011 SHALL have port i_match_ready, input, 1 bit; consumer accepts o_match.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, ITERATE, DONE.
REQ-013 SHALL drive o_req_ready = 1 only in IDLE and o_match_valid = 1 only in DONE.
REQ-014 SHALL, on a rising edge in IDLE with i_req_valid = 1, latch i_request, clear the match register, zero the iteration counter and enter ITERATE; otherwise it SHALL stay in IDLE.
REQ-015 SHALL keep one grant pointer per output (0..N-1) and one accept pointer per input (0..M-1), each binary-encoded at $clog2 width.
REQ-016 SHALL perform exactly one iteration per ITERATE cycle, considering only latched requests whose input and output are both still unmatched.
REQ-017 SHALL have each unmatched output grant the first requesting unmatched input found searching from its grant pointer upward, wrapping at N-1 to 0.
REQ-018 SHALL have each unmatched input accept the first granting output found searching from its accept pointer upward, wrapping at M-1 to 0.
REQ-019 SHALL add each accepted pair to the match register at the end of the cycle.
REQ-020 SHALL, in iteration 0 only, set each accepted pair's grant pointer of output j to (i+1) mod N and accept pointer of input i to (j+1) mod M.
REQ-021 SHALL NOT change any pointer for outputs whose grants were not accepted, or in iterations 1..ITER-1.
REQ-022 SHALL enter DONE at the end of an iteration that adds zero new pairs, or at the end of iteration ITER-1, whichever comes first.
REQ-023 SHALL therefore assert o_match_valid between 1 and ITER cycles after the request-handshake edge.
REQ-024 SHALL hold o_match and o_match_valid stable in DONE until a rising edge with i_match_ready = 1, then return to IDLE.
REQ-025 SHALL not permit a new request to be accepted in the same cycle as the match handshake, because o_req_ready = 0 in DONE.
REQ-026 SHALL guarantee at most one set bit per row and per column of o_match.
REQ-027 SHALL, for an all-zero i_request, reach DONE after one iteration with o_match all zero and pointers unchanged.
REQ-028 SHALL ignore i_request and i_req_valid outside IDLE.

Reset
REQ-029 SHALL, while reset = 1 and regardless of clk, set the state to IDLE and all pointers, the latched request, the match register and the iteration counter to 0.
REQ-030 SHALL drive these output values during reset: o_req_ready = 1, o_match_valid = 0, o_match = 0.
REQ-031 SHALL discard any in-progress schedule when reset asserts mid-ITERATE or mid-DONE.

Verification (N=M=4, ITER=3)
REQ-032 SHALL pass this test: after reset, request only [0][2] -> o_match_valid asserts 2 cycles after handshake with only [0][2] set; grant pointer of output 2 = 1; accept pointer of input 0 = 3.
REQ-033 SHALL pass this test: after reset, all-ones request -> o_match = {[0][0],[1][1],[2][2]} after 3 cycles; grant pointer of output 0 = 1; accept pointer of input 0 = 1; all other pointers = 0.
REQ-034 SHALL pass this test: a second all-ones request immediately following REQ-033 -> o_match = {[0][1],[1][0],[2][2],[3][3]}, demonstrating pointer desynchronisation.
REQ-035 SHALL pass this test: all-zero request -> o_match_valid 1 cycle after handshake, o_match = 0, all pointers unchanged.
REQ-036 SHALL pass this test: i_match_ready held low for 5 cycles in DONE -> o_match stable, o_match_valid = 1, o_req_ready = 0 throughout; raising i_match_ready -> IDLE on the next edge.
REQ-037 SHALL pass this test: reset pulsed mid-ITERATE, between edges -> immediately o_match_valid = 0, o_req_ready = 1, and all pointers = 0.
